// File: rtl/kd_tree_pkg.sv
// kd_tree_pkg: shared widths, node-word field layout and LOAD/RUN state encoding
package kd_tree_pkg;
   typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;
   function automatic int patch_width(input int nd, input int dw);
      return nd * dw;
   endfunction
   function automatic int node_width(input int dimw, input int dw);
      return dimw + dw;
   endfunction
   // node word = {dim, median}: the dim field starts right above the median
   function automatic int dim_lsb(input int dw);
      return dw;
   endfunction
endpackage

// File: rtl/kd_tree_level.sv
// kd_tree_level: one traversal stage - node select, split compare, stage registers
module kd_tree_level
   import kd_tree_pkg::*;
#(
   parameter int DEPTH = 7,
   parameter int LEVEL = 0,
   parameter int NUM_DIMS = 5,
   parameter int DATA_WIDTH = 11,
   parameter int DIM_WIDTH = 3,
   parameter int TAG_WIDTH = 8,
   localparam int PATCH_WIDTH = patch_width(NUM_DIMS, DATA_WIDTH),
   localparam int NODE_WIDTH = node_width(DIM_WIDTH, DATA_WIDTH)
)(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_flush,
   input  logic                              i_adv,
   input  logic                              i_valid,
   input  logic [DEPTH-1:0]                  i_path,
   input  logic [PATCH_WIDTH-1:0]            i_patch,
   input  logic [TAG_WIDTH-1:0]              i_tag,
   input  logic [(2**LEVEL)*NODE_WIDTH-1:0]  i_nodes,
   output logic                              o_valid,
   output logic [DEPTH-1:0]                  o_path,
   output logic [PATCH_WIDTH-1:0]            o_patch,
   output logic [TAG_WIDTH-1:0]              o_tag
);
   logic [DEPTH-1:0] w_k;
   logic [NODE_WIDTH-1:0] w_node;
   logic [DIM_WIDTH-1:0] w_dim;
   logic signed [DATA_WIDTH-1:0] w_med, w_comp;
   int w_sel;
   logic w_bit;
   logic r_valid;
   logic [DEPTH-1:0] r_path;
   logic [PATCH_WIDTH-1:0] r_patch;
   logic [TAG_WIDTH-1:0] r_tag;
   // the path only ever holds LEVEL decided bits here; masking keeps the node index in range
   assign w_k = i_path & DEPTH'((2**LEVEL) - 1);
   assign w_node = i_nodes[int'(w_k)*NODE_WIDTH +: NODE_WIDTH];
   assign w_dim = w_node[dim_lsb(DATA_WIDTH) +: DIM_WIDTH];
   assign w_med = w_node[DATA_WIDTH-1:0];
   assign w_sel = (int'(w_dim) >= NUM_DIMS) ? 0 : int'(w_dim);
   assign w_comp = i_patch[w_sel*DATA_WIDTH +: DATA_WIDTH];
   assign w_bit = w_comp > w_med;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_path <= '0;
         r_patch <= '0;
         r_tag <= '0;
      end else begin
         r_valid <= i_flush ? 1'b0 : (i_adv ? i_valid : r_valid);
         if (i_adv) begin
            r_path <= (i_path << 1) | DEPTH'(w_bit);
            r_patch <= i_patch;
            r_tag <= i_tag;
         end
      end
   end
   assign o_valid = r_valid;
   assign o_path = r_path;
   assign o_patch = r_patch;
   assign o_tag = r_tag;
endmodule

// File: rtl/kd_tree_traverse_pipe.sv
// kd_tree_traverse_pipe: loads a heap-ordered k-d tree, then classifies one patch per cycle
module kd_tree_traverse_pipe
   import kd_tree_pkg::*;
#(
   parameter int DEPTH = 7,
   parameter int NUM_DIMS = 5,
   parameter int DATA_WIDTH = 11,
   parameter int DIM_WIDTH = 3,
   parameter int TAG_WIDTH = 8,
   localparam int PATCH_WIDTH = patch_width(NUM_DIMS, DATA_WIDTH),
   localparam int NODE_WIDTH = node_width(DIM_WIDTH, DATA_WIDTH),
   localparam int NUM_NODES = 2**DEPTH - 1
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [NODE_WIDTH-1:0]  wr_data,
   input  logic                   reload,
   output logic                   loaded,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [PATCH_WIDTH-1:0] in_patch,
   input  logic [TAG_WIDTH-1:0]   in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DEPTH-1:0]       out_leaf,
   output logic [PATCH_WIDTH-1:0] out_patch,
   output logic [TAG_WIDTH-1:0]   out_tag
);
   state_t r_state, w_next;
   logic [DEPTH-1:0] r_wptr;
   logic [NUM_NODES*NODE_WIDTH-1:0] r_nodes;
   logic w_wr_fire, w_adv;
   logic w_v [0:DEPTH];
   logic [DEPTH-1:0] w_p [0:DEPTH];
   logic [PATCH_WIDTH-1:0] w_pa [0:DEPTH];
   logic [TAG_WIDTH-1:0] w_t [0:DEPTH];
   assign wr_ready = (r_state == LOAD) && !reload;
   assign w_wr_fire = wr_valid && wr_ready;
   assign w_adv = !out_valid || out_ready;
   assign in_ready = (r_state == RUN) && w_adv && !reload;
   assign loaded = r_state == RUN;
   always_comb begin
      w_next = reload ? LOAD : (w_wr_fire && r_wptr == DEPTH'(NUM_NODES - 1)) ? RUN : r_state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= LOAD;
         r_wptr <= '0;
      end else begin
         r_state <= w_next;
         r_wptr <= reload ? '0 : r_wptr + DEPTH'(w_wr_fire);
      end
   end
   // tree contents survive reset and reload until rewritten
   always_ff @(posedge clk) begin
      if (w_wr_fire) r_nodes[int'(r_wptr)*NODE_WIDTH +: NODE_WIDTH] <= wr_data;
   end
   assign w_v[0] = in_valid && in_ready;
   assign w_p[0] = '0;
   assign w_pa[0] = in_patch;
   assign w_t[0] = in_tag;
   for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
      kd_tree_level #(
         .DEPTH(DEPTH), .LEVEL(l), .NUM_DIMS(NUM_DIMS), .DATA_WIDTH(DATA_WIDTH),
         .DIM_WIDTH(DIM_WIDTH), .TAG_WIDTH(TAG_WIDTH)
      ) u_lvl (
         .clk(clk), .rst(rst), .i_flush(reload), .i_adv(w_adv),
         .i_valid(w_v[l]), .i_path(w_p[l]), .i_patch(w_pa[l]), .i_tag(w_t[l]),
         .i_nodes(r_nodes[(2**l-1)*NODE_WIDTH +: (2**l)*NODE_WIDTH]),
         .o_valid(w_v[l+1]), .o_path(w_p[l+1]), .o_patch(w_pa[l+1]), .o_tag(w_t[l+1])
      );
   end
   assign out_valid = w_v[DEPTH];
   assign out_leaf = w_p[DEPTH];
   assign out_patch = w_pa[DEPTH];
   assign out_tag = w_t[DEPTH];
endmodule

// File: tb/tb_kd_tree_traverse_pipe.sv
// tb_kd_tree_traverse_pipe: directed tests against a tree-walk model with an every-cycle scoreboard
module tb_kd_tree_traverse_pipe;
   localparam int DEPTH = 3, ND = 5, DW = 11, DIMW = 3, TW = 8;
   localparam int PW = ND * DW, NW = DIMW + DW, NN = 7;
   logic clk = 0, rst = 1, wr_valid = 0, reload = 0, in_valid = 0, out_ready = 1;
   logic [NW-1:0] wr_data = '0;
   logic [PW-1:0] in_patch = '0;
   logic [TW-1:0] in_tag = '0;
   logic wr_ready, loaded, in_ready, out_valid;
   logic [DEPTH-1:0] out_leaf;
   logic [PW-1:0] out_patch;
   logic [TW-1:0] out_tag;
   int checks = 0, errors = 0;
   int m_dim [NN], m_med [NN], t_dim [NN], t_med [NN];
   typedef struct {logic [DEPTH-1:0] leaf; logic [PW-1:0] patch; logic [TW-1:0] tag;} exp_t;
   exp_t q[$];

   kd_tree_traverse_pipe #(.DEPTH(DEPTH), .NUM_DIMS(ND), .DATA_WIDTH(DW), .DIM_WIDTH(DIMW), .TAG_WIDTH(TW)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .reload(reload), .loaded(loaded), .in_valid(in_valid), .in_ready(in_ready),
      .in_patch(in_patch), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_leaf(out_leaf), .out_patch(out_patch), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] mk(input int c0, input int c1, input int c2, input int c3, input int c4);
      int c [5];
      logic [PW-1:0] p;
      c = '{c0, c1, c2, c3, c4};
      p = '0;
      for (int d = 0; d < ND; d++) p[d*DW +: DW] = DW'(c[d]);
      return p;
   endfunction

   // walk the heap from the root: left child 2n+1, right child 2n+2
   function automatic logic [DEPTH-1:0] model_leaf(input logic [PW-1:0] p);
      int n, d, b;
      logic signed [DW-1:0] c;
      logic [DEPTH-1:0] leaf;
      n = 0;
      leaf = '0;
      for (int l = 0; l < DEPTH; l++) begin
         d = (m_dim[n] >= ND) ? 0 : m_dim[n];
         c = p[d*DW +: DW];
         b = (int'(c) > m_med[n]) ? 1 : 0;
         leaf = {leaf[DEPTH-2:0], b[0]};
         n = 2 * n + 1 + b;
      end
      return leaf;
   endfunction

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst) q.delete();
      else begin
         if (out_valid) begin
            if (q.size() == 0) chk("spurious_out_valid", 1, 0);
            else begin
               chk("sb_leaf", out_leaf, q[0].leaf);
               chk("sb_patch", out_patch, q[0].patch);
               chk("sb_tag", out_tag, q[0].tag);
               if (out_ready) void'(q.pop_front());
            end
         end
         if (reload) q.delete();
         else if (in_valid && in_ready) q.push_back('{model_leaf(in_patch), in_patch, in_tag});
      end
   end

   task automatic load_tree();
      for (int i = 0; i < NN; i++) begin
         wr_valid = 1;
         wr_data = {DIMW'(t_dim[i]), DW'(t_med[i])};
         m_dim[i] = t_dim[i];
         m_med[i] = t_med[i];
         #1;
         chk("wr_ready_loading", wr_ready, 1);
         chk("in_ready_loading", in_ready, 0);
         chk("loaded_loading", loaded, 0);
         tick();
      end
      wr_valid = 0;
      chk("wr_ready_after_load", wr_ready, 0);
      chk("loaded_after_load", loaded, 1);
      chk("in_ready_after_load", in_ready, 1);
   endtask

   task automatic do_reload();
      reload = 1;
      #1;
      chk("in_ready_in_reload", in_ready, 0);
      chk("wr_ready_in_reload", wr_ready, 0);
      tick();
      reload = 0;
      chk("loaded_after_reload", loaded, 0);
   endtask

   task automatic query_lit(input string nm, input logic [PW-1:0] p, input logic [TW-1:0] tg, input logic [DEPTH-1:0] e);
      chk({"model_", nm}, model_leaf(p), e);
      out_ready = 1;
      in_patch = p;
      in_tag = tg;
      in_valid = 1;
      #1;
      chk({nm, "_in_ready"}, in_ready, 1);
      tick();
      in_valid = 0;
      tick();
      chk({nm, "_not_early"}, out_valid, 0);
      tick();
      chk({nm, "_valid"}, out_valid, 1);
      chk({nm, "_leaf"}, out_leaf, e);
      chk({nm, "_tag"}, out_tag, tg);
      chk({nm, "_patch"}, out_patch, p);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [PW-1:0] pp [10];
      logic [DEPTH-1:0] sv_leaf;
      logic [PW-1:0] sv_patch;
      logic [TW-1:0] sv_tag;
      int idx;
      logic acc;
      repeat (2) tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_leaf", out_leaf, 0);
      chk("rst_out_patch", out_patch, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_loaded", loaded, 0);
      rst = 0;
      #1;
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_in_ready", in_ready, 0);

      t_dim = '{0, 0, 0, 0, 0, 0, 0};
      t_med = '{0, 0, 0, 0, 0, 0, 0};
      load_tree();
      query_lit("load_q", mk(-5, 0, 0, 0, 0), 8'h11, 3'b000);

      do_reload();
      t_dim = '{1, 0, 2, 0, 0, 0, 4};
      t_med = '{10, 0, -3, 0, 0, 0, 100};
      load_tree();
      query_lit("route_q", mk(0, 11, 0, 0, 100), 8'hA5, 3'b110);

      for (int i = 0; i < 19; i++) begin
         if (i < 16) begin
            in_valid = 1;
            in_patch = mk(int'($urandom_range(2047)) - 1024, int'($urandom_range(40)) - 20,
                          int'($urandom_range(40)) - 20, 0, int'($urandom_range(200)));
            in_tag = TW'(i);
            #1;
            chk("stream_in_ready", in_ready, 1);
         end else in_valid = 0;
         tick();
         if (i >= 2 && i <= 17) chk("stream_gapfree", out_valid, 1);
      end
      repeat (2) tick();
      chk("stream_drained", q.size(), 0);

      for (int i = 0; i < 10; i++)
         pp[i] = mk(int'($urandom_range(2047)) - 1024, int'($urandom_range(40)) - 20, 0, 0, 100);
      idx = 0;
      sv_leaf = '0; sv_patch = '0; sv_tag = '0;
      for (int c = 0; c < 60 && idx < 10; c++) begin
         out_ready = !(c >= 6 && c < 11);
         in_valid = 1;
         in_patch = pp[idx];
         in_tag = TW'(8'h40 + idx);
         #1;
         if (c == 6) begin
            sv_leaf = out_leaf; sv_patch = out_patch; sv_tag = out_tag;
            chk("bp_out_valid", out_valid, 1);
         end
         if (!out_ready) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_leaf_stable", out_leaf, sv_leaf);
            chk("bp_patch_stable", out_patch, sv_patch);
            chk("bp_tag_stable", out_tag, sv_tag);
         end
         acc = in_ready;
         tick();
         if (acc) idx++;
      end
      chk("bp_all_sent", idx, 10);
      in_valid = 0;
      out_ready = 1;
      repeat (5) tick();
      chk("bp_drained", q.size(), 0);

      in_valid = 1;
      in_patch = mk(3, 3, 3, 3, 3);
      in_tag = 8'h80;
      tick();
      in_tag = 8'h81;
      tick();
      wr_valid = 1;
      wr_data = {3'd7, 11'h400};
      do_reload();
      wr_valid = 0;
      in_valid = 1;
      for (int i = 0; i < 4; i++) begin
         chk("reload_flush_out_valid", out_valid, 0);
         chk("reload_in_ready", in_ready, 0);
         chk("reload_loaded", loaded, 0);
         tick();
      end
      in_valid = 0;

      t_dim = '{7, 0, 0, 0, 0, 0, 0};
      t_med = '{-1024, 5, 5, 5, 5, 5, 5};
      load_tree();
      query_lit("bnd_min_eq", mk(-1024, 0, 0, 1000, 0), 8'hB0, 3'b000);
      query_lit("bnd_max", mk(1023, 0, 0, -1000, 0), 8'hB1, 3'b111);
      query_lit("bnd_eq5", mk(5, 0, 0, -1024, 0), 8'hB2, 3'b100);

      in_valid = 1;
      in_patch = mk(1, 2, 3, 4, 5);
      in_tag = 8'hC0;
      tick();
      in_tag = 8'hC1;
      tick();
      in_valid = 0;
      rst = 1;
      tick();
      rst = 0;
      chk("midrst_loaded", loaded, 0);
      chk("midrst_leaf", out_leaf, 0);
      chk("midrst_tag", out_tag, 0);
      for (int i = 0; i < 4; i++) begin
         chk("midrst_out_valid", out_valid, 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
